// File: rtl/wu_ook_tx_pkg.sv
// Shared wake-up radio definitions: field widths, default timing and the TX FSM encoding.
package wu_ook_tx_pkg;

  localparam int unsigned WuPreLenW  = 4;
  localparam int unsigned WuSyncW    = 16;
  localparam int unsigned WuPayloadW = 32;
  localparam int unsigned WuPayLenW  = 6;

  localparam int unsigned WuBitDivDefault     = 100000;
  localparam int unsigned WuWakeCycDefault    = 1000;
  localparam int unsigned WuSvcTimeoutDefault = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StPreamble,
    StSync,
    StPayload,
    StWaitSvc,
    StFinish
  } wu_state_e;

  // Lengths beyond the payload register are sent as a full payload.
  function automatic logic [WuPayLenW-1:0] wu_clamp_len(input logic [WuPayLenW-1:0] len);
    return (len > WuPayLenW'(WuPayloadW)) ? WuPayLenW'(WuPayloadW) : len;
  endfunction

endpackage

// File: rtl/wu_ook_tx_if.sv
// Packet request / OOK line bundle between a host and the wake-up transmitter.
interface wu_ook_tx_if;
  import wu_ook_tx_pkg::*;

  logic                  start;
  logic [WuPreLenW-1:0]  preamble_len;
  logic [WuSyncW-1:0]    sync_word;
  logic [WuPayloadW-1:0] payload;
  logic [WuPayLenW-1:0]  payload_len;
  logic                  wu_serviced;
  logic                  wake_up;
  logic                  ook_out;
  logic                  bit_strobe;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;

  modport master (
    output start, preamble_len, sync_word, payload, payload_len, wu_serviced,
    input  wake_up, ook_out, bit_strobe, busy, done, timeout_err
  );

  modport slave (
    input  start, preamble_len, sync_word, payload, payload_len, wu_serviced,
    output wake_up, ook_out, bit_strobe, busy, done, timeout_err
  );

endinterface

// File: rtl/wu_bit_timer.sv
// Bit-period divider for the OOK transmitter: bit boundaries, registered bit strobe and
// the acknowledgement timeout counted in whole bit periods.
module wu_bit_timer
  import wu_ook_tx_pkg::*;
#(
  parameter int unsigned BIT_DIV     = WuBitDivDefault,
  parameter int unsigned SVC_TIMEOUT = WuSvcTimeoutDefault
) (
  input  logic clki,
  input  logic reset,
  input  logic run,
  input  logic tmo_en,
  input  logic strobe_req,
  output logic bit_last,
  output logic tmo_expired,
  output logic bit_strobe
);

  localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned TmoW = $clog2(SVC_TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            strobe_q;

  assign bit_last    = (cnt_q == CntW'(BIT_DIV - 1));
  assign tmo_expired = tmo_en && bit_last && (tmo_q == TmoW'(SVC_TIMEOUT - 1));
  assign bit_strobe  = strobe_q;

  always_comb begin
    cnt_d = '0;
    tmo_d = '0;
    // Counter idles at zero so the first bit of a packet always starts a fresh period.
    if (run) begin
      cnt_d = bit_last ? '0 : cnt_q + 1'b1;
    end
    if (tmo_en) begin
      tmo_d = bit_last ? tmo_q + 1'b1 : tmo_q;
    end
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      cnt_q    <= '0;
      tmo_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      strobe_q <= strobe_req;
    end
  end

endmodule

// File: rtl/wu_ook_tx.sv
// Wake-up radio OOK transmitter: wake pulse, preamble/sync/payload bit stream, then waits
// for the receiver acknowledgement or a timeout.
module wu_ook_tx
  import wu_ook_tx_pkg::*;
#(
  parameter int unsigned BIT_DIV     = WuBitDivDefault,
  parameter int unsigned WAKE_CYC    = WuWakeCycDefault,
  parameter int unsigned SVC_TIMEOUT = WuSvcTimeoutDefault
) (
  input  logic           clki,
  input  logic           reset,
  wu_ook_tx_if.slave     bus
);

  localparam int unsigned WakeW = $clog2(WAKE_CYC + 1);

  wu_state_e             state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [WakeW-1:0]      wake_cnt_q, wake_cnt_d;
  logic [WuPreLenW-1:0]  pre_len_q;
  logic [WuSyncW-1:0]    sync_q;
  logic [WuPayloadW-1:0] pay_q;
  logic [WuPayLenW-1:0]  pay_len_q;
  logic                  wake_q, wake_d;
  logic                  ook_q, ook_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic                  latch;
  logic                  strobe_req;
  logic                  bit_last;
  logic                  tmo_expired;
  logic                  bit_strobe;
  logic [3:0]            sync_sel;
  logic [4:0]            pay_sel;

  wu_bit_timer #(
    .BIT_DIV     (BIT_DIV),
    .SVC_TIMEOUT (SVC_TIMEOUT)
  ) u_bit_timer (
    .clki        (clki),
    .reset       (reset),
    .run         ((state_q == StPreamble) || (state_q == StSync) ||
                  (state_q == StPayload) || (state_q == StWaitSvc)),
    .tmo_en      (state_q == StWaitSvc),
    .strobe_req  (strobe_req),
    .bit_last    (bit_last),
    .tmo_expired (tmo_expired),
    .bit_strobe  (bit_strobe)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wake_cnt_d = wake_cnt_q;
    latch      = 1'b0;
    strobe_req = 1'b0;
    done_d     = 1'b0;
    tmo_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          latch      = 1'b1;
          state_d    = StWake;
          wake_cnt_d = '0;
        end
      end
      StWake: begin
        if (wake_cnt_q == WakeW'(WAKE_CYC - 1)) begin
          state_d    = (pre_len_q != '0) ? StPreamble : StSync;
          idx_d      = '0;
          strobe_req = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      StPreamble: begin
        if (bit_last) begin
          strobe_req = 1'b1;
          if (6'(idx_q + 6'd1) == {1'b0, pre_len_q, 1'b0}) begin
            state_d = StSync;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      StSync: begin
        if (bit_last) begin
          if (idx_q == 6'd15) begin
            idx_d = '0;
            if (pay_len_q != '0) begin
              state_d    = StPayload;
              strobe_req = 1'b1;
            end else begin
              state_d = StWaitSvc;
            end
          end else begin
            idx_d      = idx_q + 6'd1;
            strobe_req = 1'b1;
          end
        end
      end
      StPayload: begin
        if (bit_last) begin
          if (idx_q == pay_len_q - 6'd1) begin
            state_d = StWaitSvc;
            idx_d   = '0;
          end else begin
            idx_d      = idx_q + 6'd1;
            strobe_req = 1'b1;
          end
        end
      end
      StWaitSvc: begin
        // Acknowledgement is checked first so it wins over a coincident timeout.
        if (bus.wu_serviced) begin
          state_d = StFinish;
          done_d  = 1'b1;
        end else if (tmo_expired) begin
          state_d = StFinish;
          tmo_d   = 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    sync_sel = 4'd15 - idx_d[3:0];
    pay_sel  = 5'(pay_len_q - 6'd1 - idx_d);

    unique case (state_d)
      StPreamble: ook_d = ~idx_d[0];
      StSync:     ook_d = sync_q[sync_sel];
      StPayload:  ook_d = pay_q[pay_sel];
      default:    ook_d = 1'b0;
    endcase

    wake_d = (state_d == StWake);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wake_cnt_q <= '0;
      pre_len_q  <= '0;
      sync_q     <= '0;
      pay_q      <= '0;
      pay_len_q  <= '0;
      wake_q     <= 1'b0;
      ook_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wake_cnt_q <= wake_cnt_d;
      wake_q     <= wake_d;
      ook_q      <= ook_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      if (latch) begin
        pre_len_q <= bus.preamble_len;
        sync_q    <= bus.sync_word;
        pay_q     <= bus.payload;
        pay_len_q <= wu_clamp_len(bus.payload_len);
      end
    end
  end

  assign bus.wake_up     = wake_q;
  assign bus.ook_out     = ook_q;
  assign bus.bit_strobe  = bit_strobe;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;

endmodule
